// File: rtl/stream_buffer.sv
// stream_buffer: FIFO staging buffer storing one DATA_W word per cycle and streaming LANES words per beat.
// Optional macro STREAM_BUF_ZERO_PAD_EN: issue zero-padded partial beats when 0 < count < LANES.
module stream_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LANES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [1:0]              state,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic                    out_valid,
    output logic [ADDR_W:0]         count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow
);
    localparam int unsigned     DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LANES_C = (ADDR_W + 1)'(LANES);

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_STORE  = 2'b01,
        CMD_STREAM = 2'b10,
        CMD_BOTH   = 2'b11
    } cmd_e;

    cmd_e                    cmd;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic [LANES*DATA_W-1:0] data_q, beat_d;
    logic                    valid_q;
    logic                    overflow_q;
    logic                    store_req, stream_req, can_issue, do_store, do_issue;
    logic [ADDR_W:0]         issue_cnt;

    assign cmd = cmd_e'(state);

    always_comb begin
        store_req  = (cmd == CMD_STORE)  || (cmd == CMD_BOTH);
        stream_req = (cmd == CMD_STREAM) || (cmd == CMD_BOTH);
        can_issue  = !valid_q || out_ready;
        // Full check uses the pre-edge count, so a same-edge issue never frees a slot
        do_store   = store_req && (count_q != DEPTH_C);
        issue_cnt  = '0;
        if (stream_req && can_issue) begin
            if (count_q >= LANES_C)
                issue_cnt = LANES_C;
`ifdef STREAM_BUF_ZERO_PAD_EN
            else
                issue_cnt = count_q;
`else
            else
                issue_cnt = '0;
`endif
        end
        do_issue = (issue_cnt != '0);

        // Oldest element lands in the MSB lane; lanes past issue_cnt stay zero
        beat_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if ((ADDR_W + 1)'(i) < issue_cnt)
                beat_d[(LANES - 1 - i) * DATA_W +: DATA_W] = mem_q[rd_ptr_q + ADDR_W'(i)];
        end

        wr_ptr_d = wr_ptr_q + ADDR_W'(do_store);
        rd_ptr_d = rd_ptr_q + issue_cnt[ADDR_W-1:0];
        count_d  = count_q + (ADDR_W + 1)'(do_store) - issue_cnt;
    end

    always_ff @(posedge clk) begin
        if (do_store && !flush)
            mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (store_req && !do_store)
                overflow_q <= 1'b1;
            if (do_issue) begin
                data_q  <= beat_d;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);

endmodule
